// File: rtl/hilo_pkg.sv
// hilo_pkg: op encodings, default width and divider FSM states shared by the HI/LO unit
package hilo_pkg;
   localparam int W_DEF = 32;
   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6
   } op_e;
   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t FIX  = 2'd2;
endpackage

// File: rtl/hilo_if.sv
// hilo_if: CPU-side request, read and handshake bus of the HI/LO unit
interface hilo_if import hilo_pkg::*; #(parameter int W = W_DEF);
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] busA;
   logic [W-1:0] busB;
   logic         rd_en;
   logic         rd_hi;
   logic [W-1:0] rd_data;
   logic         busy;
   logic         stall;
   logic         done;
   modport master (output start, op, busA, busB, rd_en, rd_hi, input rd_data, busy, stall, done);
   modport slave  (input start, op, busA, busB, rd_en, rd_hi, output rd_data, busy, stall, done);
endinterface

// File: rtl/div_iter.sv
// div_iter: unsigned restoring divider, one quotient bit per cycle after load
module div_iter #(
   parameter int W = 32,
   parameter int N = W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         valid
);
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] ONE = CW'(1);
   logic [CW-1:0] cnt;
   logic [W-1:0]  d;
   logic [W:0]    shifted, trial;
   logic          active, fits;
   // quotient doubles as the dividend shift register; divisor 0 yields all-ones and remainder = dividend
   assign shifted = {remainder, quotient[W-1]};
   assign trial = shifted - {1'b0, d};
   assign fits = ~trial[W];
   assign valid = active && cnt == ONE;
   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         cnt <= '0;
         d <= '0;
         quotient <= '0;
         remainder <= '0;
      end else if (load) begin
         active <= 1'b1;
         cnt <= CW'(N);
         d <= divisor;
         quotient <= dividend;
         remainder <= '0;
      end else if (active) begin
         remainder <= fits ? trial[W-1:0] : shifted[W-1:0];
         quotient <= {quotient[W-2:0], fits};
         cnt <= cnt - ONE;
         active <= ~valid;
      end
   end
endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register pair with one-cycle multiply, iterative divide and MFHI/MFLO reads
module hilo_unit import hilo_pkg::*; #(
   parameter int W = W_DEF,
   parameter int DIV_CYCLES = W
) (
   input logic   clk,
   input logic   rst,
   hilo_if.slave bus
);
   state_t         state;
   logic [W-1:0]   hi, lo, mag_a, mag_b, quo, rem;
   logic [2*W-1:0] prod;
   logic           busy, done, acc, sx, go_div, last, neg_q, neg_r, dz;
   assign busy = state != IDLE;
   assign acc = bus.start & ~busy;
   assign sx = bus.op == OP_MULT || bus.op == OP_DIV;
   assign go_div = acc && (bus.op == OP_DIV || bus.op == OP_DIVU);
   assign mag_a = (sx && bus.busA[W-1]) ? -bus.busA : bus.busA;
   assign mag_b = (sx && bus.busB[W-1]) ? -bus.busB : bus.busB;
   // low 2W bits of the extended operands give the signed or unsigned product alike
   assign prod = {{W{sx & bus.busA[W-1]}}, bus.busA} * {{W{sx & bus.busB[W-1]}}, bus.busB};
   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.stall = busy & (bus.rd_en | bus.start);
   assign bus.rd_data = bus.rd_hi ? hi : lo;
   div_iter #(.W(W), .N(DIV_CYCLES)) u_div (
      .clk(clk),
      .rst(rst),
      .load(go_div),
      .dividend(mag_a),
      .divisor(mag_b),
      .quotient(quo),
      .remainder(rem),
      .valid(last)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         hi <= '0;
         lo <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dz <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= state == FIX;
         state <= go_div ? RUN : (state == RUN && last) ? FIX : (state == FIX) ? IDLE : state;
         if (acc && (bus.op == OP_MULT || bus.op == OP_MULTU)) {hi, lo} <= prod;
         if (acc && bus.op == OP_MTHI) hi <= bus.busA;
         if (acc && bus.op == OP_MTLO) lo <= bus.busA;
         if (go_div) begin
            neg_q <= sx & (bus.busA[W-1] ^ bus.busB[W-1]);
            neg_r <= sx & bus.busA[W-1];
            dz <= bus.busB == '0;
         end
         // a zero divisor leaves rem = |busA|, so the remainder sign fix already restores busA into HI
         if (state == FIX) begin
            lo <= dz ? '1 : neg_q ? -quo : quo;
            hi <= neg_r ? -rem : rem;
         end
      end
   end
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed and random stimulus against an arithmetic reference model of the HI/LO unit
module tb_hilo_unit;
   import hilo_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   hilo_if #(.W(32)) bus ();
   hilo_unit #(.W(32), .DIV_CYCLES(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   int checks = 0;
   int failures = 0;
   bit armed = 1'b0;
   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   int m_cnt = 0;
   logic m_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (b == 0) begin
         q = 32'hFFFFFFFF;
         r = a;
      end else if (!s) begin
         q = a / b;
         r = a % b;
      end else begin
         q = 32'(sa / sb);
         r = 32'(sa % sb);
      end
   endfunction

   // reference: divides land 33 edges after acceptance, everything else on the accepting edge
   always @(posedge clk) begin
      logic [63:0] p;
      if (rst) begin
         m_hi = '0;
         m_lo = '0;
         m_cnt = 0;
         m_done = 1'b0;
         armed = 1'b1;
      end else begin
         m_done = 1'b0;
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_hi = p_hi;
               m_lo = p_lo;
               m_done = 1'b1;
            end
         end else if (bus.start) begin
            case (bus.op)
               OP_MULT: begin
                  p = 64'(longint'($signed(bus.busA)) * longint'($signed(bus.busB)));
                  {m_hi, m_lo} = p;
               end
               OP_MULTU: begin
                  p = 64'(bus.busA) * 64'(bus.busB);
                  {m_hi, m_lo} = p;
               end
               OP_DIV: begin
                  ref_div(1'b1, bus.busA, bus.busB, p_lo, p_hi);
                  m_cnt = 33;
               end
               OP_DIVU: begin
                  ref_div(1'b0, bus.busA, bus.busB, p_lo, p_hi);
                  m_cnt = 33;
               end
               OP_MTHI: m_hi = bus.busA;
               OP_MTLO: m_lo = bus.busA;
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("rd_data", bus.rd_data, bus.rd_hi ? m_hi : m_lo);
         chk("busy", 32'(bus.busy), 32'(m_cnt > 0));
         chk("stall", 32'(bus.stall), 32'((m_cnt > 0) && (bus.rd_en || bus.start)));
         chk("done", 32'(bus.done), 32'(m_done));
      end
   end

   task automatic cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.op = op;
      bus.busA = a;
      bus.busB = b;
      cycle();
      bus.start = 1'b0;
   endtask

   task automatic read_lit(input logic hi, input logic [31:0] exp, input string name);
      bus.rd_en = 1'b1;
      bus.rd_hi = hi;
      @(negedge clk);
      chk(name, bus.rd_data, exp);
      cycle();
      bus.rd_en = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         ok = !bus.busy;
      end
      chk(name, 32'(bus.busy), 32'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return $urandom;
         1: return 32'($urandom_range(0, 20));
         2: return 32'd0;
         3: return 32'h80000000;
         4: return 32'hFFFFFFFF;
         default: return -32'($urandom_range(1, 20));
      endcase
   endfunction

   initial begin
      int nb, nd;
      bus.start = 1'b0;
      bus.op = OP_NOP;
      bus.busA = '0;
      bus.busB = '0;
      bus.rd_en = 1'b0;
      bus.rd_hi = 1'b0;
      repeat (2) cycle();
      rst = 1'b0;
      read_lit(1'b1, 32'h0, "reset_hi");
      read_lit(1'b0, 32'h0, "reset_lo");
      do_op(OP_MULT, 32'hFFFFFFFE, 32'd3);
      chk("mult_busy", 32'(bus.busy), 32'd0);
      read_lit(1'b1, 32'hFFFFFFFF, "mult_hi");
      read_lit(1'b0, 32'hFFFFFFFA, "mult_lo");
      do_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
      nb = 0;
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         nb += int'(bus.busy);
         nd += int'(bus.done);
      end
      cycle();
      chk("div_busy_cycles", 32'(nb), 32'd33);
      chk("div_done_pulses", 32'(nd), 32'd1);
      read_lit(1'b0, 32'hFFFFFFFD, "div_lo");
      read_lit(1'b1, 32'hFFFFFFFF, "div_hi");
      do_op(OP_DIVU, 32'd100, 32'd0);
      wait_idle("divu0_idle");
      cycle();
      read_lit(1'b0, 32'hFFFFFFFF, "divu0_lo");
      read_lit(1'b1, 32'd100, "divu0_hi");
      do_op(OP_DIV, 32'd1000, 32'd7);
      repeat (4) cycle();
      bus.rd_en = 1'b1;
      bus.rd_hi = 1'b1;
      bus.start = 1'b1;
      bus.op = OP_MULT;
      bus.busA = 32'd5;
      bus.busB = 32'd5;
      @(negedge clk);
      chk("mfhi_stall", 32'(bus.stall), 32'd1);
      chk("mfhi_old", bus.rd_data, 32'd100);
      cycle();
      bus.start = 1'b0;
      @(negedge clk);
      chk("mfhi_stall_hold", 32'(bus.stall), 32'd1);
      wait_idle("mfhi_idle");
      chk("mfhi_new", bus.rd_data, 32'd6);
      chk("mfhi_unstall", 32'(bus.stall), 32'd0);
      cycle();
      read_lit(1'b0, 32'd142, "mfhi_lo_not_mult");
      bus.start = 1'b1;
      bus.op = OP_MTHI;
      bus.busA = 32'h1234;
      cycle();
      bus.op = OP_MTLO;
      bus.busA = 32'h5678;
      bus.rd_en = 1'b1;
      bus.rd_hi = 1'b0;
      @(negedge clk);
      chk("mtlo_old_lo", bus.rd_data, 32'd142);
      cycle();
      bus.start = 1'b0;
      read_lit(1'b1, 32'h1234, "mthi_hi");
      read_lit(1'b0, 32'h5678, "mtlo_lo");
      do_op(OP_DIV, 32'd50, 32'd5);
      repeat (9) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      bus.rd_en = 1'b1;
      bus.rd_hi = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_lo", bus.rd_data, 32'd0);
      cycle();
      read_lit(1'b1, 32'd0, "abort_hi");
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         nd += int'(bus.done);
      end
      chk("abort_no_done", 32'(nd), 32'd0);
      cycle();
      do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_idle("ovf_idle");
      cycle();
      read_lit(1'b0, 32'h80000000, "ovf_lo");
      read_lit(1'b1, 32'h0, "ovf_hi");
      do_op(OP_DIVU, 32'd9, 32'd2);
      wait_idle("b2b_idle");
      bus.start = 1'b1;
      bus.op = OP_MULTU;
      bus.busA = 32'hFFFFFFFF;
      bus.busB = 32'd2;
      cycle();
      bus.start = 1'b0;
      read_lit(1'b1, 32'd1, "b2b_hi");
      read_lit(1'b0, 32'hFFFFFFFE, "b2b_lo");
      for (int i = 0; i < 2000; i++) begin
         rst = $urandom_range(0, 149) == 0;
         bus.start = $urandom_range(0, 1) == 1;
         bus.op = 3'($urandom_range(0, 6));
         bus.busA = pick();
         bus.busB = pick();
         bus.rd_en = $urandom_range(0, 1) == 1;
         bus.rd_hi = $urandom_range(0, 1) == 1;
         cycle();
      end
      rst = 1'b0;
      bus.start = 1'b0;
      repeat (40) cycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hilo_unit.md
# hilo_unit

Sequential HI/LO register unit for the single-cycle MIPS datapath. Accepts multiply, divide and move-to operations. Holds the 64-bit HI/LO result pair and serves MFHI/MFLO reads back onto the writeback bus. Multiplies complete in one cycle. Divides run on an iterative radix-2 divider, and the CPU is stalled through a busy/stall handshake until the result lands.

## Interface
Parameters:
- W, 32, operand and HI/LO register width
- DIV_CYCLES, W, number of divider iteration cycles (fixed equal to W)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  operation request, valid for one cycle
- op  in  3  operation code: NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO
- busA  in  W  rs operand (dividend, multiplicand, MTHI/MTLO source)
- busB  in  W  rt operand (divisor, multiplier)
- rd_en  in  1  MFHI/MFLO read request
- rd_hi  in  1  1 = read HI, 0 = read LO
- rd_data  out  W  combinational HI or LO value
- busy  out  1  divider in progress
- stall  out  1  CPU must hold the PC and the current instruction
- done  out  1  one-cycle pulse when the divide result is written

## Operation
- Reset: HI=0, LO=0, busy=0, done=0, divider state cleared. Reset mid-divide aborts the divide with no HI/LO write.
- Accept rule: start is accepted only when busy=0. A start while busy=1 is not accepted, and stall is raised.
- MULT: {HI,LO} <= signed(busA)*signed(busB), full 2W-bit product.
- MULTU: {HI,LO} <= unsigned product, full 2W-bit result.
- MTHI: HI <= busA; LO unchanged.
- MTLO: LO <= busA; HI unchanged.
- DIVU: LO <= busA/busB, HI <= busA%busB, unsigned.
- DIV: operates on magnitudes, then fixes signs.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (both signednesses): LO=0xFFFFFFFF, HI=busA. The full iteration count still elapses.
- Divider FSM states:
  - IDLE -> RUN on an accepted DIV/DIVU.
  - RUN counts DIV_CYCLES iterations (shift-subtract-restore, one quotient bit per cycle).
  - RUN -> FIX after the last iteration.
  - FIX applies sign correction, writes HI/LO, pulses done, and returns to IDLE.
- rd_data = rd_hi ? HI : LO, taken from the registers and never from divider internals.
- stall = busy & (rd_en | start).

## Timing
- MULT/MULTU/MTHI/MTLO: accepted at edge E0. HI/LO hold the new value after E0, and an MFLO in the next cycle reads it. busy stays low.
- DIV/DIVU:
  - Accepted at edge E0; busy=1 from after E0.
  - RUN occupies edges E1..E32.
  - FIX is written at E33; busy=0 and done=1 in the cycle after E33.
  - Total latency is DIV_CYCLES+1 = 33 edges.
- Operands are latched at E0. busA/busB may change afterwards.
- Read in the same cycle as a MULT accept returns the old HI/LO (read-before-write).
- Read while busy: stall=1 and rd_data is the old value. The CPU must retry after busy falls.
- A start on the same cycle busy falls (after E33) is accepted normally.

## Structure
- Shared package `hilo_pkg`: op encodings (NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6), W default, and FSM state typedef {IDLE, RUN, FIX}.
- Sub-module `div_iter`: the unsigned restoring divider.
  - Interface: load, dividend, divisor -> quotient, remainder, valid.
- Sign handling, the multiplier and the HI/LO registers stay in `hilo_unit`.

## Test plan
- MULT busA=0xFFFFFFFE (-2), busB=3 -> after one edge HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy never high.
- DIV busA=-7 (0xFFFFFFF9), busB=2 -> busy for 33 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); done pulses once.
- DIVU busA=100, busB=0 -> after 33 cycles LO=0xFFFFFFFF, HI=100.
- MFHI (rd_en=1, rd_hi=1) issued 5 cycles into a divide -> stall=1 until busy falls. rd_data then equals the new HI. A MULT start issued mid-divide is ignored.
- MTHI 0x1234, then MTLO 0x5678 on consecutive cycles -> HI=0x1234, LO=0x5678; same-cycle MFLO with MTLO returns the old LO.
- Reset asserted at iteration 10 of DIV 50/5 -> busy=0 and HI=LO=0 next cycle; no done pulse.
